// File: rtl/wsp_shift_sequencer.sv
// wsp_shift_sequencer
// Upstream IEEE 1500 WSP driver. A start pulse runs one wrapper access: shift an
// opcode into WIR and update it, then optionally capture/shift/update a data
// register while unloading WSO into a parallel word.
// The FSM state advances on WRCK; every WSP output is a flop computed from the
// current state, so the strobes trail the state register by one cycle.

module wsp_shift_sequencer #(
    parameter int WIR_LEN = 3,
    parameter int DR_LEN  = 12
) (
    input  logic               WRCK,
    input  logic               RESET,
    input  logic               start,
    input  logic [WIR_LEN-1:0] instr,
    input  logic               skip_dr,
    input  logic [DR_LEN-1:0]  dr_in,
    input  logic               WSO,
    output logic               SelectWIR,
    output logic               CaptureWR,
    output logic               ShiftWR,
    output logic               UpdateWR,
    output logic               WSI,
    output logic [DR_LEN-1:0]  dr_out,
    output logic               busy,
    output logic               done
);

    localparam int MAX_LEN = (WIR_LEN > DR_LEN) ? WIR_LEN : DR_LEN;
    localparam int CW      = $clog2(MAX_LEN) + 1;

    localparam logic [CW-1:0] WIR_LAST = CW'(WIR_LEN - 1);
    localparam logic [CW-1:0] DR_LAST  = CW'(DR_LEN - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WIR_SHIFT = 3'd1,
        ST_WIR_UPD   = 3'd2,
        ST_DR_CAP    = 3'd3,
        ST_DR_SHIFT  = 3'd4,
        ST_DR_UPD    = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIR_LEN-1:0] instr_q, instr_d;
    logic [DR_LEN-1:0]  drl_q, drl_d;
    logic               skip_q, skip_d;

    logic               sel_q, sel_d;
    logic               cap_q, cap_d;
    logic               shift_q, shift_d;
    logic               upd_q, upd_d;
    logic               wsi_q, wsi_d;
    logic [DR_LEN-1:0]  dr_out_q, dr_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state, shift counter and operand latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        drl_d   = drl_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                // done_q high means the DONE cycle is still visible; start is ignored there.
                if (start && !done_q) begin
                    instr_d = instr;
                    drl_d   = dr_in;
                    skip_d  = skip_dr;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_WIR_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WIR_SHIFT: begin
                if (cnt_q == WIR_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_WIR_UPD;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_WIR_UPD: begin
                if (skip_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DR_CAP;
                end
            end
            ST_DR_CAP: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_DR_SHIFT;
            end
            ST_DR_SHIFT: begin
                if (cnt_q == DR_LAST) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_DR_UPD;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DR_UPD: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // WSP strobe/data decode from the current state, plus the WSO capture shifter.
    always_comb begin
        sel_d   = 1'b0;
        cap_d   = 1'b0;
        shift_d = 1'b0;
        upd_d   = 1'b0;
        wsi_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_WIR_SHIFT: begin
                sel_d   = 1'b1;
                shift_d = 1'b1;
                wsi_d   = |(instr_q & (WIR_LEN'(1'b1) << cnt_q));
            end
            ST_WIR_UPD: begin
                sel_d = 1'b1;
                upd_d = 1'b1;
            end
            ST_DR_CAP: begin
                cap_d = 1'b1;
            end
            ST_DR_SHIFT: begin
                shift_d = 1'b1;
                wsi_d   = |(drl_q & (DR_LEN'(1'b1) << cnt_q));
            end
            ST_DR_UPD: begin
                upd_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);

        // WSO is taken on the edge closing each visible DR shift cycle; it enters at
        // the MSB so that after DR_LEN shifts dr_out[k] holds sample k.
        if (shift_q && !sel_q) begin
            dr_out_d = DR_LEN'({WSO, dr_out_q} >> 1);
        end else begin
            dr_out_d = dr_out_q;
        end
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge WRCK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            instr_q  <= {WIR_LEN{1'b0}};
            drl_q    <= {DR_LEN{1'b0}};
            skip_q   <= 1'b0;
            sel_q    <= 1'b0;
            cap_q    <= 1'b0;
            shift_q  <= 1'b0;
            upd_q    <= 1'b0;
            wsi_q    <= 1'b0;
            dr_out_q <= {DR_LEN{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            drl_q    <= drl_d;
            skip_q   <= skip_d;
            sel_q    <= sel_d;
            cap_q    <= cap_d;
            shift_q  <= shift_d;
            upd_q    <= upd_d;
            wsi_q    <= wsi_d;
            dr_out_q <= dr_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SelectWIR = sel_q;
    assign CaptureWR = cap_q;
    assign ShiftWR   = shift_q;
    assign UpdateWR  = upd_q;
    assign WSI       = wsi_q;
    assign dr_out    = dr_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
